// File: rtl/edge_grad_3x3.sv
// edge_grad_3x3: 3x3 Sobel/Prewitt gradient magnitude stage, 4-stage pipe with global stall.
// Define EDGE_DIR_EN to add the dst_dir edge-direction output.
module edge_grad_3x3 #(
  parameter int DATA_W = 8,
  parameter int CNT_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CNT_W-1:0]      img_width,
  input  logic [CNT_W-1:0]      img_height,
  input  logic                  cfg_kernel,
  input  logic                  cfg_mag,
  input  logic [1:0]            cfg_shift,
  input  logic                  cfg_thr_en,
  input  logic [DATA_W-1:0]     cfg_thr,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [9*DATA_W-1:0]   src_data,
  output logic                  dst_valid,
  input  logic                  dst_ready,
  output logic [DATA_W-1:0]     dst_data,
  output logic                  dst_sof,
  output logic                  dst_eol
`ifdef EDGE_DIR_EN
  ,
  output logic [1:0]            dst_dir
`endif
);
  localparam int PW = DATA_W + 2;
  localparam int MW = DATA_W + 3;
  typedef struct packed {
    logic [1:0]        shift;
    logic              thr_en;
    logic [DATA_W-1:0] thr;
  } ocfg_t;
  typedef struct packed {
    logic  kernel;
    logic  mag;
    ocfg_t o;
  } cfg_t;
  typedef struct packed {
    logic v;
    logic sof;
    logic eol;
  } tag_t;
  typedef struct packed {
    tag_t          t;
    logic          mag;
    ocfg_t         o;
    logic [PW-1:0] l;
    logic [PW-1:0] r;
    logic [PW-1:0] tp;
    logic [PW-1:0] b;
  } s1_t;
  typedef struct packed {
    tag_t          t;
    logic          mag;
    ocfg_t         o;
    logic [PW-1:0] ax;
    logic [PW-1:0] ay;
`ifdef EDGE_DIR_EN
    logic          sx;
    logic          sy;
`endif
  } s2_t;
  typedef struct packed {
    tag_t          t;
    ocfg_t         o;
    logic [MW-1:0] m;
`ifdef EDGE_DIR_EN
    logic [1:0]    dir;
`endif
  } s3_t;

  function automatic logic [PW-1:0] wsum(input logic k, input logic [DATA_W-1:0] a, b, c);
    return PW'(a) + PW'(c) + (k ? PW'(b) : PW'(b) << 1);
  endfunction

  function automatic logic [PW-1:0] adiff(input logic [PW-1:0] a, b);
    return a >= b ? a - b : b - a;
  endfunction

  logic adv, acc, first, last_col, last_row;
  logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
  cfg_t cfg_q, cfg_d, cfg_in, cur;
  s1_t s1_q, s1_d;
  s2_t s2_q, s2_d;
  s3_t s3_q, s3_d;
  logic dv_q, dv_d, sof_q, sof_d, eol_q, eol_d;
  logic [DATA_W-1:0] data_q, data_d, sat, res;
  logic [MW-1:0] sh;
  logic [DATA_W-1:0] p [9];

  for (genvar i = 0; i < 9; i++) begin : g_px
    assign p[i] = src_data[i*DATA_W +: DATA_W];
  end

  assign adv = !dv_q || dst_ready;
  assign src_ready = adv;
  assign acc = src_valid && adv;
  assign first = col_q == '0 && row_q == '0;
  assign last_col = col_q == img_width - CNT_W'(1);
  assign last_row = row_q == img_height - CNT_W'(1);
  assign cfg_in = {cfg_kernel, cfg_mag, cfg_shift, cfg_thr_en, cfg_thr};
  // The frame-start window uses the live config; the rest of the frame uses the latched copy.
  assign cur = first ? cfg_in : cfg_q;

  always_comb begin
    col_d = acc ? (last_col ? '0 : col_q + CNT_W'(1)) : col_q;
    row_d = acc && last_col ? (last_row ? '0 : row_q + CNT_W'(1)) : row_q;
    cfg_d = acc && first ? cfg_in : cfg_q;
  end

  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    if (adv) begin
      s1_d.t = {acc, acc && first, acc && last_col};
      s1_d.mag = cur.mag;
      s1_d.o = cur.o;
      s1_d.l = wsum(cur.kernel, p[0], p[3], p[6]);
      s1_d.r = wsum(cur.kernel, p[2], p[5], p[8]);
      s1_d.tp = wsum(cur.kernel, p[0], p[1], p[2]);
      s1_d.b = wsum(cur.kernel, p[6], p[7], p[8]);
      s2_d.t = s1_q.t;
      s2_d.mag = s1_q.mag;
      s2_d.o = s1_q.o;
      s2_d.ax = adiff(s1_q.r, s1_q.l);
      s2_d.ay = adiff(s1_q.b, s1_q.tp);
`ifdef EDGE_DIR_EN
      s2_d.sx = s1_q.r < s1_q.l;
      s2_d.sy = s1_q.b < s1_q.tp;
`endif
      s3_d.t = s2_q.t;
      s3_d.o = s2_q.o;
      s3_d.m = s2_q.mag ? MW'(s2_q.ax > s2_q.ay ? s2_q.ax : s2_q.ay) : MW'(s2_q.ax) + MW'(s2_q.ay);
`ifdef EDGE_DIR_EN
      s3_d.dir = {s2_q.ay, 1'b0} < {1'b0, s2_q.ax} ? 2'd0 :
                 {s2_q.ax, 1'b0} < {1'b0, s2_q.ay} ? 2'd2 : {s2_q.sx != s2_q.sy, 1'b1};
`endif
    end
  end

  always_comb begin
    sh = s3_q.m >> s3_q.o.shift;
    sat = |sh[MW-1:DATA_W] ? '1 : sh[DATA_W-1:0];
    res = s3_q.o.thr_en ? {DATA_W{sat >= s3_q.o.thr}} : sat;
    dv_d = adv ? s3_q.t.v : dv_q;
    sof_d = adv ? s3_q.t.sof : sof_q;
    eol_d = adv ? s3_q.t.eol : eol_q;
    data_d = adv ? res : data_q;
  end

`ifdef EDGE_DIR_EN
  logic [1:0] dir_q, dir_d;
  always_comb dir_d = adv ? s3_q.dir : dir_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) dir_q <= '0;
    else dir_q <= dir_d;
  assign dst_dir = dir_q;
`endif

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
      cfg_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
      dv_q <= 1'b0;
      sof_q <= 1'b0;
      eol_q <= 1'b0;
      data_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      cfg_q <= cfg_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
      dv_q <= dv_d;
      sof_q <= sof_d;
      eol_q <= eol_d;
      data_q <= data_d;
    end

  assign dst_valid = dv_q;
  assign dst_data = data_q;
  assign dst_sof = sof_q;
  assign dst_eol = eol_q;
endmodule

// File: tb/tb_edge_grad_3x3.sv
// tb_edge_grad_3x3: random and directed stimulus against a plain-arithmetic gradient model.
module tb_edge_grad_3x3;
  localparam int DW = 8;
  localparam int CW = 12;
  localparam int MAXV = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] img_width = CW'(1);
  logic [CW-1:0] img_height = CW'(1);
  logic cfg_kernel = 1'b0, cfg_mag = 1'b0, cfg_thr_en = 1'b0;
  logic [1:0] cfg_shift = 2'd0;
  logic [DW-1:0] cfg_thr = '0;
  logic src_valid = 1'b0, dst_ready = 1'b0;
  logic src_ready, dst_valid, dst_sof, dst_eol;
  logic [9*DW-1:0] src_data = '0;
  logic [DW-1:0] dst_data;
`ifdef EDGE_DIR_EN
  logic [1:0] dst_dir;
  int last_dir = 0;
`endif

  edge_grad_3x3 #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .img_width(img_width), .img_height(img_height),
    .cfg_kernel(cfg_kernel), .cfg_mag(cfg_mag), .cfg_shift(cfg_shift),
    .cfg_thr_en(cfg_thr_en), .cfg_thr(cfg_thr),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
    .dst_sof(dst_sof), .dst_eol(dst_eol)
`ifdef EDGE_DIR_EN
    , .dst_dir(dst_dir)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {int d; int sof; int eol; int dir;} exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  int mcol = 0, mrow = 0, lk = 0, lm = 0, ls = 0, lte = 0, lt = 0;
  int outs = 0, accs = 0, last_d = 0, last_sof = 0;
  logic hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_px(input int k, input int v);
    src_data[k*DW +: DW] = DW'(v);
  endtask

  task automatic set_step(input int l, input int m, input int r);
    for (int row = 0; row < 3; row++) begin
      set_px(row*3, l);
      set_px(row*3+1, m);
      set_px(row*3+2, r);
    end
  endtask

  task automatic set_cfg(input int k, input int m, input int s, input int te, input int t);
    cfg_kernel = k[0];
    cfg_mag = m[0];
    cfg_shift = 2'(s);
    cfg_thr_en = te[0];
    cfg_thr = DW'(t);
  endtask

  function automatic exp_t model(input int k, input int m, input int s, input int te, input int t);
    int p[9];
    int w, l, r, tp, b, gx, gy, ax, ay, mag, v;
    exp_t e;
    for (int i = 0; i < 9; i++) p[i] = int'(src_data[i*DW +: DW]);
    w = k != 0 ? 1 : 2;
    l = p[0] + w*p[3] + p[6];
    r = p[2] + w*p[5] + p[8];
    tp = p[0] + w*p[1] + p[2];
    b = p[6] + w*p[7] + p[8];
    gx = r - l;
    gy = b - tp;
    ax = gx < 0 ? -gx : gx;
    ay = gy < 0 ? -gy : gy;
    mag = m != 0 ? (ax > ay ? ax : ay) : ax + ay;
    v = mag >> s;
    if (v > MAXV) v = MAXV;
    if (te != 0) v = v >= t ? MAXV : 0;
    e.d = v;
    e.dir = 2*ay < ax ? 0 : 2*ax < ay ? 2 : ((gx < 0) == (gy < 0)) ? 1 : 3;
    e.sof = 0;
    e.eol = 0;
    return e;
  endfunction

  // One clock cycle, entered and left on the falling edge.
  task automatic cyc(input logic sv, input logic rdy);
    exp_t e;
    src_valid = sv;
    dst_ready = rdy;
    #1;
    chk("src_ready", int'(src_ready), int'(!dst_valid || dst_ready));
    if (hold_v) begin
      chk("hold_valid", int'(dst_valid), 1);
      chk("hold_data", int'(dst_data), int'(hold_d));
    end
    if (dst_valid && dst_ready) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("data", int'(dst_data), e.d);
        chk("sof", int'(dst_sof), e.sof);
        chk("eol", int'(dst_eol), e.eol);
`ifdef EDGE_DIR_EN
        chk("dir", int'(dst_dir), e.dir);
        last_dir = int'(dst_dir);
`endif
      end
      last_d = int'(dst_data);
      last_sof = int'(dst_sof);
      outs++;
    end
    if (src_valid && src_ready) begin
      if (mcol == 0 && mrow == 0) begin
        lk = int'(cfg_kernel); lm = int'(cfg_mag); ls = int'(cfg_shift);
        lte = int'(cfg_thr_en); lt = int'(cfg_thr);
      end
      e = model(lk, lm, ls, lte, lt);
      e.sof = int'(mcol == 0 && mrow == 0);
      e.eol = int'(mcol == int'(img_width) - 1);
      q.push_back(e);
      if (mcol == int'(img_width) - 1) begin
        mcol = 0;
        mrow = mrow == int'(img_height) - 1 ? 0 : mrow + 1;
      end else mcol++;
      accs++;
    end
    hold_v = dst_valid && !dst_ready;
    hold_d = dst_data;
    @(negedge clk);
  endtask

  task automatic one(input string tag, input int k, input int m, input int s, input int te,
                     input int t, input int exp_d);
    int n = 0;
    int o0 = outs;
    set_cfg(k, m, s, te, t);
    cyc(1'b1, 1'b1);
    do begin
      n++;
      cyc(1'b0, 1'b1);
    end while (outs == o0 && n < 20);
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_data"}, last_d, exp_d);
    chk({tag, "_sof"}, last_sof, 1);
  endtask

  task automatic rand_px();
    for (int k = 0; k < 9; k++) set_px(k, int'($urandom_range(0, MAXV)));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int o0, a0, n;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(dst_valid), 0);
    chk("rst_data", int'(dst_data), 0);
    chk("rst_sof", int'(dst_sof), 0);
    chk("rst_eol", int'(dst_eol), 0);
    chk("rst_ready", int'(src_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    // Single-window frames: every window is a frame start.
    for (int k = 0; k < 9; k++) set_px(k, 10);
    one("flat", 0, 0, 0, 0, 0, 0);
    set_step(0, 128, 255);
    one("step_s0", 0, 0, 0, 0, 0, 255);
    one("step_s3", 0, 0, 3, 0, 0, 127);
    one("step_prewitt", 1, 0, 2, 0, 0, 191);
    for (int k = 0; k < 9; k++) set_px(k, 200);
    set_px(0, 0);
    one("diag_max", 0, 1, 1, 0, 0, 100);
`ifdef EDGE_DIR_EN
    chk("diag_dir", last_dir, 1);
`endif
    set_step(0, 0, 40);
    one("thr_low", 0, 0, 2, 1, 100, 0);
    set_step(0, 0, 120);
    one("thr_high", 0, 0, 2, 1, 100, 255);

    // Random traffic with backpressure and per-cycle config churn.
    img_width = CW'(4);
    img_height = CW'(2);
    o0 = outs;
    a0 = accs;
    n = 0;
    while (accs - a0 < 64 && n < 3000) begin
      rand_px();
      set_cfg(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3) == 0), int'($urandom_range(0, MAXV)));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0);
      n++;
    end
    n = 0;
    while (outs - o0 < 64 && n < 500) begin
      cyc(1'b0, $urandom_range(0, 1) != 0);
      n++;
    end
    chk("bp_accepted", accs - a0, 64);
    chk("bp_outputs", outs - o0, 64);
    chk("bp_queue_empty", q.size(), 0);

    // Threshold enable raised mid-frame must wait for the next frame start.
    img_width = CW'(4);
    img_height = CW'(1);
    set_step(0, 0, 120);
    set_cfg(0, 0, 2, 0, 0);
    cyc(1'b1, 1'b1);
    set_cfg(0, 0, 2, 1, 200);
    repeat (3) cyc(1'b1, 1'b1);
    repeat (6) cyc(1'b0, 1'b1);
    chk("thr_midframe", last_d, 120);
    one("thr_nextframe", 0, 0, 2, 1, 100, 255);

    // Reset while the third window of a frame is presented and older outputs are in flight.
    repeat (5) begin
      rand_px();
      cyc(1'b1, 1'b1);
    end
    rand_px();
    src_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", int'(dst_valid), 0);
    chk("midrst_data", int'(dst_data), 0);
    chk("midrst_sof", int'(dst_sof), 0);
    src_valid = 1'b0;
    #2;
    rst = 1'b0;
    q.delete();
    mcol = 0;
    mrow = 0;
    hold_v = 1'b0;
    @(negedge clk);
    o0 = outs;
    repeat (3) begin
      rand_px();
      cyc(1'b1, 1'b1);
    end
    repeat (8) cyc(1'b0, 1'b1);
    chk("midrst_outputs", outs - o0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/edge_grad_3x3.md
Name: edge_grad_3x3

Overview:
- Parametrised successor to the fixed 8-bit Sobel stage.
- Takes a flattened 3x3 window stream from the line-buffer block and computes horizontal and vertical gradients.
- Kernel is runtime-selectable (Sobel/Prewitt); magnitude is L1 or max, with shift scaling, saturation and optional thresholding.
- Full valid/ready backpressure, frame position flags, and per-frame config latching; sits between block_3x3 and output packing/DDR writeback.

Parameters:
- DATA_W, 8: pixel bit width (4..12).
- CNT_W, 12: width of the column/row counters and the img_width/img_height inputs.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- img_width  in  CNT_W  pixels per line, >=1
- img_height  in  CNT_W  lines per frame, >=1
- cfg_kernel  in  1  0=Sobel (weights 1,2,1), 1=Prewitt (1,1,1)
- cfg_mag  in  1  0=L1 (|gx|+|gy|), 1=max(|gx|,|gy|)
- cfg_shift  in  2  right shift applied to magnitude before saturation
- cfg_thr_en  in  1  binarise output
- cfg_thr  in  DATA_W  threshold
- src_valid  in  1  window valid
- src_ready  out  1  block accepts window
- src_data  in  9*DATA_W  window; pixel k=row*3+col at [k*DATA_W +: DATA_W], row0=top, col0=left
- dst_valid  out  1  result valid
- dst_ready  in  1  sink accepts result
- dst_data  out  DATA_W  edge magnitude
- dst_sof  out  1  first pixel of frame
- dst_eol  out  1  last pixel of line

Behaviour:
- Reset: all pipeline valids 0; dst_valid, dst_data, dst_sof, dst_eol all 0; counters 0; latched config = Sobel, L1, shift 0, thr off.
- Clock and reset: one clock; reset is asynchronous and active-high.
- Handshake: transfer on valid&&ready at each side.
  - 4-stage pipeline with a global stall.
  - src_ready = !dst_valid || dst_ready, combinational.
  - When stalled every stage holds; dst_data and flags stay stable while dst_valid && !dst_ready.
- Latency: 4 cycles from src accept to dst_valid when unstalled; throughput 1 per cycle.
- S1, partial sums, width DATA_W+2, unsigned, per kernel weights w=(1,2,1) or (1,1,1):
  - L = w·(p0,p3,p6)
  - R = w·(p2,p5,p8)
  - T = w·(p0,p1,p2)
  - B = w·(p6,p7,p8)
- S2: |gx| = |R-L|, |gy| = |B-T|, width DATA_W+2; the sign bits sx = R<L and sy = B<T travel down the pipe.
- S3 magnitude:
  - L1 mode: |gx|+|gy|, width DATA_W+3.
  - Max mode: max(|gx|,|gy|), zero-extended to DATA_W+3.
- S4 output:
  - m = mag >> cfg_shift.
  - dst_data = all-ones if m >= 2^DATA_W, else m[DATA_W-1:0].
  - If thr_en: dst_data = all-ones when the saturated value >= cfg_thr, else 0.
- Config latching:
  - All cfg_* are captured on the accepted window with col=0,row=0 and apply to that whole frame.
  - cfg changes mid-frame are ignored until the next frame start.
  - The latched values are carried alongside the data, so a frame's tail is unaffected by the next frame's config.
- Counters:
  - col/row count accepted src windows.
  - col wraps at img_width-1 and increments row; row wraps at img_height-1 back to 0.
  - sof = (col==0 && row==0), eol = (col==img_width-1); both flags are pipelined with the data.
- img_width/img_height are sampled continuously; changing them mid-frame is undefined and must not be done.
- Reset mid-frame: all in-flight data is discarded, counters return to 0, and the next accepted window is sof.

Optional Feature:
- EDGE_DIR_EN defined: adds output dst_dir (2 bits), aligned with dst_data and stalled with it.
  - 0 = |gy|*2 < |gx| (vertical edge)
  - 2 = |gx|*2 < |gy| (horizontal edge)
  - otherwise 1 when sx==sy, 3 when sx!=sy
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Flat window, all pixels 10, Sobel, L1 -> dst_data=0 after exactly 4 cycles; dst_sof=1 on the first output.
- Vertical step (left col 0, mid 128, right 255), DATA_W=8, Sobel:
  - shift 0 -> 255 (saturated, raw 1020)
  - shift 3 -> 127
  - Prewitt, shift 2 -> 191 (765>>2)
- Diagonal window p0=0 and others 200, max mode, shift 1 -> gx=gy=200, dst_data=100; with EDGE_DIR_EN, dst_dir=1.
- Threshold on, thr=100: vertical step values 40 -> 0 and 120 -> 255 (Sobel, shift 2).
  - Toggle cfg_thr_en mid-frame -> no effect until the next sof.
- Backpressure: random dst_ready at 50%, 64 windows, img_width=4, img_height=2:
  - output sequence equals the unstalled reference run;
  - dst_data held while stalled;
  - eol on every 4th output, sof on the 1st and 9th outputs.
- Assert rst during the 3rd pixel of a frame -> dst_valid=0 immediately; the next accepted window produces sof=1; no stale output appears.
